// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 matrix keypad scanner with frame-based debounce and a
// valid/ack key-event handshake.
// Optional feature macro: KEYPAD_HEX_MAP_EN -- when defined, key codes follow
// the printed hex layout instead of the raw row*4+col index.
module keypad_scanner #(
  parameter int SCAN_DIV        = 50000,
  parameter int DEBOUNCE_FRAMES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output logic [3:0] key_code,
  output logic       key_valid,
  input  logic       key_ack,
  output logic       key_down,
  output logic       overrun
);

  localparam int             DW       = $clog2(SCAN_DIV);
  localparam logic [DW-1:0]  DIV_LAST = DW'(SCAN_DIV - 1);
  localparam logic [3:0]     DB_N     = 4'(DEBOUNCE_FRAMES);

  typedef enum logic [1:0] {S_IDLE, S_PRESS_DB, S_HELD, S_RELEASE_DB} state_t;

  // Key index (row*4+col) to reported code.
  function automatic logic [3:0] key_map(input logic [3:0] k);
`ifdef KEYPAD_HEX_MAP_EN
    logic [3:0] m;
    case (k)
      4'd0:  m = 4'h1;  4'd1:  m = 4'h2;  4'd2:  m = 4'h3;  4'd3:  m = 4'hA;
      4'd4:  m = 4'h4;  4'd5:  m = 4'h5;  4'd6:  m = 4'h6;  4'd7:  m = 4'hB;
      4'd8:  m = 4'h7;  4'd9:  m = 4'h8;  4'd10: m = 4'h9;  4'd11: m = 4'hC;
      4'd12: m = 4'hE;  4'd13: m = 4'h0;  4'd14: m = 4'hF;  default: m = 4'hD;
    endcase
    return m;
`else
    return k;
`endif
  endfunction

  logic [3:0]    sync1_q, sync2_q;
  logic [DW-1:0] div_q, div_d;
  logic [1:0]    col_q, col_d;
  logic [15:0]   frame_q, frame_d;
  logic          eval_q, eval_d;
  state_t        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [3:0]    cand_q, cand_d;
  logic [3:0]    key_code_q, key_code_d;
  logic          key_valid_q, key_valid_d;
  logic          key_down_q, key_down_d;
  logic          overrun_q, overrun_d;

  // Frame classification outputs
  logic [4:0]    n_bits;
  logic [3:0]    k_idx;
  logic          is_single;
  logic          cand_bit;
  logic          accept;
  logic [3:0]    cnt_inc;

  assign col_out   = ~(4'b0001 << col_q);
  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign key_down  = key_down_q;
  assign overrun   = overrun_q;

  // Column scan: divide counter, column step, and sampling of the active
  // column's rows into the frame image on the last divide cycle.
  always_comb begin
    div_d   = div_q + DW'(1);
    col_d   = col_q;
    frame_d = frame_q;
    eval_d  = 1'b0;
    if (div_q == DIV_LAST) begin
      div_d = '0;
      col_d = col_q + 2'd1;
      for (int r = 0; r < 4; r++) frame_d[r*4 + int'(col_q)] = ~sync2_q[r];
      eval_d = (col_q == 2'd3);
    end
  end

  // Count set bits in the finished frame and remember the (last) set index.
  always_comb begin
    n_bits = '0;
    k_idx  = '0;
    for (int i = 0; i < 16; i++) begin
      if (frame_q[i]) begin
        n_bits = n_bits + 5'd1;
        k_idx  = 4'(i);
      end
    end
    is_single = (n_bits == 5'd1);
    cand_bit  = frame_q[cand_q];
    cnt_inc   = cnt_q + 4'd1;
  end

  // Debounce FSM next state; runs only on the cycle after the column-3 sample.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cand_d  = cand_q;
    accept  = 1'b0;
    if (eval_q) begin
      case (state_q)
        S_IDLE: begin
          if (is_single) begin
            cand_d = k_idx;
            if (DB_N == 4'd1) begin
              state_d = S_HELD;
              cnt_d   = '0;
              accept  = 1'b1;
            end else begin
              state_d = S_PRESS_DB;
              cnt_d   = 4'd1;
            end
          end
        end
        S_PRESS_DB: begin
          if (is_single && k_idx == cand_q) begin
            if (cnt_inc >= DB_N) begin
              state_d = S_HELD;
              cnt_d   = '0;
              accept  = 1'b1;
            end else begin
              cnt_d = cnt_inc;
            end
          end else begin
            state_d = S_IDLE;
            cnt_d   = '0;
          end
        end
        S_HELD: begin
          // With single-frame debounce the first released frame is final.
          if (!cand_bit) begin
            if (DB_N == 4'd1) begin
              state_d = S_IDLE;
              cnt_d   = '0;
            end else begin
              state_d = S_RELEASE_DB;
              cnt_d   = 4'd1;
            end
          end
        end
        default: begin
          if (!cand_bit) begin
            if (cnt_inc >= DB_N) begin
              state_d = S_IDLE;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_inc;
            end
          end else begin
            state_d = S_HELD;
            cnt_d   = '0;
          end
        end
      endcase
    end
  end

  // Handshake outputs: accept loads a new code unless an unconsumed event
  // is pending, in which case the new key is dropped and overrun latches.
  always_comb begin
    key_code_d  = key_code_q;
    key_valid_d = key_valid_q;
    overrun_d   = overrun_q;
    if (key_ack && key_valid_q) begin
      key_valid_d = 1'b0;
      overrun_d   = 1'b0;
    end
    if (accept) begin
      if (!key_valid_q || key_ack) begin
        key_code_d  = key_map(k_idx);
        key_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
    key_down_d = (state_d == S_HELD) || (state_d == S_RELEASE_DB);
  end

  // All state registers, synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q     <= 4'hF;
      sync2_q     <= 4'hF;
      div_q       <= '0;
      col_q       <= '0;
      frame_q     <= '0;
      eval_q      <= 1'b0;
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      cand_q      <= '0;
      key_code_q  <= '0;
      key_valid_q <= 1'b0;
      key_down_q  <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      sync1_q     <= row_in;
      sync2_q     <= sync1_q;
      div_q       <= div_d;
      col_q       <= col_d;
      frame_q     <= frame_d;
      eval_q      <= eval_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cand_q      <= cand_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      key_down_q  <= key_down_d;
      overrun_q   <= overrun_d;
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: scoreboard bench for keypad_scanner (SCAN_DIV=4,
// DEBOUNCE_FRAMES=2). A keypad model pulls a row low while its pressed key's
// column is driven; expected key events are queued when a press is applied
// and compared when key_valid rises.
module tb_keypad_scanner;
  localparam int FR   = 16;          // clocks per frame
  localparam int TMO  = 3*FR + 8;    // bound for a debounce decision

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] row_in;
  logic [3:0] col_out;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_ack = 1'b0;
  logic       key_down;
  logic       overrun;

  logic [15:0] keys = '0;            // bit r*4+c = key (r,c) pressed
  logic [3:0]  exp_q[$];
  logic [3:0]  exp_code;
  logic        prev_valid = 1'b0;
  int          n_tests = 0;
  int          n_fail  = 0;
  int          ev_count = 0;

  keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_FRAMES(2)) dut (
    .clk(clk), .rst(rst), .row_in(row_in), .col_out(col_out),
    .key_code(key_code), .key_valid(key_valid), .key_ack(key_ack),
    .key_down(key_down), .overrun(overrun)
  );

  always #5 clk = ~clk;

  // Keypad matrix: row r low if any pressed key in row r has its column driven low.
  always_comb begin
    for (int r = 0; r < 4; r++) begin
      row_in[r] = 1'b1;
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !col_out[c]) row_in[r] = 1'b0;
    end
  end

  function automatic logic [3:0] kmap(input int k);
`ifdef KEYPAD_HEX_MAP_EN
    logic [3:0] t [16] = '{4'h1, 4'h2, 4'h3, 4'hA, 4'h4, 4'h5, 4'h6, 4'hB,
                           4'h7, 4'h8, 4'h9, 4'hC, 4'hE, 4'h0, 4'hF, 4'hD};
    return t[k];
`else
    return 4'(k);
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Scoreboard: every rising key_valid must match the oldest expected press.
  always @(negedge clk) begin
    if (key_valid && !prev_valid) begin
      if (exp_q.size() == 0) chk("sb_unexpected", 1, 0);
      else begin
        exp_code = exp_q.pop_front();
        chk("sb_code", key_code, exp_code);
      end
      ev_count++;
    end
    prev_valid = key_valid;
  end

  // Wait (bounded) for key_valid (which=0) or key_down (which=1) to equal val.
  task automatic wait_for(input string tag, input int which, input logic val, input int maxc);
    logic cur;
    cur = ~val;
    for (int i = 0; i < maxc; i++) begin
      @(negedge clk);
      cur = (which == 0) ? key_valid : key_down;
      if (cur == val) break;
    end
    chk(tag, cur, val);
  endtask

  // Align to the start of a scan frame (column 0 just became active).
  task automatic sync_frame();
    int i;
    i = 0;
    while (col_out != 4'b0111 && i < 64) begin @(negedge clk); i++; end
    while (col_out != 4'b1110 && i < 64) begin @(negedge clk); i++; end
    chk("frame_align", col_out, 4'b1110);
  endtask

  task automatic pulse_ack();
    @(posedge clk); #1 key_ack = 1'b1;
    @(posedge clk); #1 key_ack = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_col", col_out, 4'b1110);
    chk("rst_valid", key_valid, 0);
    chk("rst_down", key_down, 0);
    chk("rst_ovr", overrun, 0);
    chk("rst_code", key_code, 0);
    @(posedge clk); #1 rst = 1'b0;
  endtask

  initial begin
    logic [3:0] ex;
    int ev0, any_v, any_d;

    // Reset and column scan sequence
    do_reset();
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      ex = ~(4'b0001 << (i/4));
      chk("col_scan", col_out, ex);
    end

    // Clean press of (2,3)
    keys = 16'(1) << 11;
    exp_q.push_back(kmap(11));
    repeat (FR) @(negedge clk);
    chk("press_early", key_valid, 0);
    wait_for("press_valid", 0, 1'b1, TMO);
    chk("press_down", key_down, 1);
    chk("press_code", key_code, kmap(11));
    repeat (8*FR) @(negedge clk);
    chk("hold_valid", key_valid, 1);
    chk("hold_down", key_down, 1);
    keys = '0;
    repeat (FR) @(negedge clk);
    chk("rel_early", key_down, 1);
    wait_for("rel_down", 1, 1'b0, TMO);
    chk("rel_valid_kept", key_valid, 1);
    pulse_ack();
    chk("ack_valid", key_valid, 0);

    // Bounce on (0,1), then stable
    ev0 = ev_count;
    exp_q.push_back(kmap(1));
    for (int i = 0; i < 10; i++) begin
      keys = keys ^ (16'(1) << 1);
      repeat (5) @(posedge clk);
    end
    keys = 16'(1) << 1;
    wait_for("bounce_valid", 0, 1'b1, 2*TMO);
    repeat (3*FR) @(negedge clk);
    chk("bounce_events", ev_count - ev0, 1);
    chk("bounce_code", key_code, kmap(1));
    keys = '0;
    wait_for("bounce_rel", 1, 1'b0, TMO);
    pulse_ack();
    chk("bounce_ack", key_valid, 0);

    // Ghost: two keys together from idle
    sync_frame();
    keys = (16'(1) << 0) | (16'(1) << 5);
    any_v = 0; any_d = 0;
    for (int i = 0; i < 6*FR; i++) begin
      @(negedge clk);
      if (key_valid) any_v = 1;
      if (key_down) any_d = 1;
    end
    chk("ghost_valid", any_v, 0);
    chk("ghost_down", any_d, 0);
    sync_frame();
    keys = '0;
    repeat (2*FR) @(negedge clk);

    // Overrun: (0,2) unacked, then (3,1) dropped
    keys = 16'(1) << 2;
    exp_q.push_back(kmap(2));
    wait_for("ovr_first", 0, 1'b1, TMO);
    keys = '0;
    wait_for("ovr_rel", 1, 1'b0, TMO);
    keys = 16'(1) << 13;
    wait_for("ovr_second_down", 1, 1'b1, TMO);
    chk("ovr_flag", overrun, 1);
    chk("ovr_code", key_code, kmap(2));
    pulse_ack();
    chk("ovr_ack_valid", key_valid, 0);
    chk("ovr_ack_flag", overrun, 0);
    keys = '0;
    wait_for("ovr_rel2", 1, 1'b0, TMO);

    // Reset while HELD, key kept pressed
    keys = 16'(1) << 6;
    exp_q.push_back(kmap(6));
    wait_for("rh_valid", 0, 1'b1, TMO);
    exp_q.push_back(kmap(6));
    do_reset();
    wait_for("rh_valid_again", 0, 1'b1, TMO);
    chk("rh_down", key_down, 1);
    keys = '0;
    wait_for("rh_rel", 1, 1'b0, TMO);
    pulse_ack();

    chk("sb_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
